// File: rtl/aes_sbox_pkg.sv
// Shared constants for the depth-16 AES S-box forward top linear layer.
// Each TOP_FWD_MASK entry selects the U bits whose XOR forms one T bit.
package aes_sbox_pkg;

  localparam int U_W = 8;
  localparam int T_W = 27;

  typedef logic [U_W-1:0] u_byte_t;
  typedef logic [T_W-1:0] t_word_t;

  localparam u_byte_t TOP_FWD_MASK [0:T_W-1] = '{
    8'h09, 8'h21, 8'h41, 8'h28, 8'h50, 8'h59, 8'h06, 8'hD9, 8'h86,
    8'h5F, 8'h22, 8'h24, 8'h69, 8'h7B, 8'h72, 8'h74, 8'hF2, 8'h88,
    8'h8E, 8'h87, 8'hC0, 8'hC6, 8'hE7, 8'h7E, 8'h75, 8'h35, 8'h2D
  };

  // XOR of all 27 masks above: parity of T reduces to this single U mask.
  localparam u_byte_t TOP_FWD_PAR_MASK = 8'hDD;

endpackage

// File: rtl/top_linear_mask_lane.sv
// Combinational 8->27 top linear mask evaluator for one byte lane.
// With TOP_LINEAR_PARITY_EN defined it also produces the predicted parity of T.
module top_linear_mask_lane
  import aes_sbox_pkg::*;
(
  input  logic [U_W-1:0] u,
`ifdef TOP_LINEAR_PARITY_EN
  output logic           p,
`endif
  output logic [T_W-1:0] t
);

  always_comb begin
    t = '0;
    for (int i = 0; i < T_W; i++) begin
      t[i] = ^(u & TOP_FWD_MASK[i]);
    end
  end

`ifdef TOP_LINEAR_PARITY_EN
  assign p = ^(u & TOP_FWD_PAR_MASK);
`endif

endmodule

// File: rtl/top_linear_pipe.sv
// Multi-lane pipelined forward top linear layer with valid/ready, flush and beat counter.
// Optional per-lane parity checking is built when TOP_LINEAR_PARITY_EN is defined.
module top_linear_pipe
  import aes_sbox_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [U_W*LANES-1:0]   in_u,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [T_W*LANES-1:0]   out_t,
`ifdef TOP_LINEAR_PARITY_EN
  output logic [LANES-1:0]       par_err,
`endif
  output logic [CNT_W-1:0]       beat_cnt
);

  logic [T_W*LANES-1:0] t_comb;
  logic [T_W*LANES-1:0] t_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] vld_q;
  logic [PIPE_STAGES-1:0] stage_open;
  logic accept;

`ifdef TOP_LINEAR_PARITY_EN
  logic [LANES-1:0] p_comb;
  logic [LANES-1:0] p_q [PIPE_STAGES];
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    top_linear_mask_lane u_lane (
      .u (in_u[U_W*l +: U_W]),
`ifdef TOP_LINEAR_PARITY_EN
      .p (p_comb[l]),
`endif
      .t (t_comb[T_W*l +: T_W])
    );
  end

  // A stage can take new data when empty or when its contents move on; the
  // chain only runs backwards from out_ready, so valids never feed valids.
  always_comb begin
    logic nxt;
    nxt        = out_ready;
    stage_open = '0;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      stage_open[k] = !vld_q[k] || nxt;
      nxt           = stage_open[k];
    end
  end

  assign in_ready = !flush && stage_open[0];
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q    <= '0;
      beat_cnt <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        t_q[k] <= '0;
`ifdef TOP_LINEAR_PARITY_EN
        p_q[k] <= '0;
`endif
      end
    end else begin
      if (accept) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (flush) begin
        vld_q <= '0;
      end else begin
        if (stage_open[0]) begin
          vld_q[0] <= in_valid;
        end
        if (accept) begin
          t_q[0] <= t_comb;
`ifdef TOP_LINEAR_PARITY_EN
          p_q[0] <= p_comb;
`endif
        end
        for (int k = 1; k < PIPE_STAGES; k++) begin
          if (stage_open[k]) begin
            vld_q[k] <= vld_q[k-1];
            if (vld_q[k-1]) begin
              t_q[k] <= t_q[k-1];
`ifdef TOP_LINEAR_PARITY_EN
              p_q[k] <= p_q[k-1];
`endif
            end
          end
        end
      end
    end
  end

  assign out_valid = vld_q[PIPE_STAGES-1];
  assign out_t     = t_q[PIPE_STAGES-1];

`ifdef TOP_LINEAR_PARITY_EN
  // Parity is recomputed from the presented T so corruption anywhere in the pipe shows up.
  always_comb begin
    par_err = '0;
    for (int l = 0; l < LANES; l++) begin
      par_err[l] = out_valid && (p_q[PIPE_STAGES-1][l] ^ (^out_t[T_W*l +: T_W]));
    end
  end
`endif

endmodule

// File: tb/tb_top_linear_pipe.sv
// Directed self-checking bench for top_linear_pipe (LANES=4, PIPE_STAGES=2, CNT_W=4).
// Define TOP_LINEAR_PARITY_EN for both bench and RTL to exercise the parity checks.
module tb_top_linear_pipe;

  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int CNT_W  = 4;

  // T contribution of each individual U bit (column view of the top linear matrix).
  localparam logic [26:0] TCOL [8] = '{
    27'h74832A7, 27'h0ED6740, 27'h7EC8B40, 27'h48632A9,
    27'h381E2B0, 27'h7C1FC0A, 27'h1F1F2B4, 27'h07F0180
  };

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   in_u;
  logic                 out_valid;
  logic                 out_ready;
  logic [27*LANES-1:0]  out_t;
  logic [CNT_W-1:0]     beat_cnt;
`ifdef TOP_LINEAR_PARITY_EN
  logic [LANES-1:0]     par_err;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [27*LANES-1:0] expq [$];
  logic [CNT_W-1:0]    exp_cnt;

  always #5 clk = ~clk;

  top_linear_pipe #(
    .LANES       (LANES),
    .PIPE_STAGES (STAGES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_u      (in_u),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_t     (out_t),
`ifdef TOP_LINEAR_PARITY_EN
    .par_err   (par_err),
`endif
    .beat_cnt  (beat_cnt)
  );

  function automatic logic [26:0] lane_t(input logic [7:0] u);
    logic [26:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) if (u[j]) r = r ^ TCOL[j];
    return r;
  endfunction

  function automatic logic [27*LANES-1:0] golden(input logic [8*LANES-1:0] u);
    logic [27*LANES-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[27*l +: 27] = lane_t(u[8*l +: 8]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_u      = '0;
    out_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    vectors++;
    if (out_t !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_t: got %h expected 0", out_t);
    end
    vectors++;
    if (beat_cnt !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_beat_cnt: got %0d expected 0", beat_cnt);
    end
    reset_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    exp_cnt = '0;
    expq.delete();
  endtask

  task automatic test_spec_vectors();
    logic [27*LANES-1:0] want;
    want      = {27'h7373327, 27'h07F0180, 27'h74832A7, 27'h0000000};
    out_ready = 1'b1;
    in_u      = {8'h81, 8'h80, 8'h01, 8'h00};
    in_valid  = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL vec_in_ready: got %b expected 1", in_ready);
    end
    tick();
    exp_cnt++;
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL vec_latency_early: got %b expected 0", out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL vec_latency: got %b expected 1", out_valid);
    end
    vectors++;
    if (out_t !== want) begin
      miscompares++;
      $display("[TB] FAIL vec_out_t: got %h expected %h", out_t, want);
    end
    vectors++;
    if (beat_cnt !== exp_cnt) begin
      miscompares++;
      $display("[TB] FAIL vec_beat_cnt: got %0d expected %0d", beat_cnt, exp_cnt);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL vec_drained: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_sweep();
    int got      = 0;
    int accepted = 0;
    int first_c  = -1;
    int last_c   = -1;
    logic [7:0] b;
    logic [27*LANES-1:0] want;
    out_ready = 1'b1;
    for (int c = 0; c < 256 + STAGES + 3; c++) begin
      b        = c[7:0];
      in_valid = (c < 256);
      in_u     = {b + 8'hC0, b + 8'h80, b + 8'h40, b};
      #1;
      if (out_valid && out_ready) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL sweep_extra_output: got %h expected none", out_t);
        end else begin
          want = expq.pop_front();
          if (out_t !== want) begin
            miscompares++;
            $display("[TB] FAIL sweep_out_t[%0d]: got %h expected %h", got, out_t, want);
          end
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(golden(in_u));
        accepted++;
        exp_cnt++;
      end
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (accepted != 256) begin
      miscompares++;
      $display("[TB] FAIL sweep_throughput: got %0d accepted expected 256", accepted);
    end
    vectors++;
    if (got != 256) begin
      miscompares++;
      $display("[TB] FAIL sweep_count: got %0d outputs expected 256", got);
    end
    vectors++;
    if (first_c != STAGES || last_c != STAGES + 255) begin
      miscompares++;
      $display("[TB] FAIL sweep_timing: got first %0d last %0d expected %0d %0d",
               first_c, last_c, STAGES, STAGES + 255);
    end
    vectors++;
    if (beat_cnt !== exp_cnt) begin
      miscompares++;
      $display("[TB] FAIL sweep_beat_cnt: got %0d expected %0d", beat_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] beat_u [6] = '{32'h01020304, 32'hA5A55A5A, 32'hFF00FF00,
                                32'h80402010, 32'h0F1E2D3C, 32'hDEADBEEF};
    int nb  = 0;
    int got = 0;
    logic [27*LANES-1:0] want;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 6);
      in_valid  = (nb < 6);
      in_u      = beat_u[(nb < 6) ? nb : 0];
      #1;
      if (c >= 2 && c <= 5) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL stall_in_ready[c%0d]: got %b expected 0", c, in_ready);
        end
        vectors++;
        if (out_valid !== 1'b1 || out_t !== golden(beat_u[0])) begin
          miscompares++;
          $display("[TB] FAIL stall_hold[c%0d]: got %b/%h expected 1/%h",
                   c, out_valid, out_t, golden(beat_u[0]));
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (expq.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL stall_extra_output: got %h expected none", out_t);
        end else begin
          want = expq.pop_front();
          if (out_t !== want) begin
            miscompares++;
            $display("[TB] FAIL stall_out_t[%0d]: got %h expected %h", got, out_t, want);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(golden(in_u));
        nb++;
        exp_cnt++;
      end
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (got != 6 || nb != 6) begin
      miscompares++;
      $display("[TB] FAIL stall_count: got %0d out %0d in expected 6 6", got, nb);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_u     = {8'h10, 8'h20, 8'h30, c[7:0]};
      #1;
      if (in_ready) exp_cnt++;
      tick();
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_prefill: got %b expected 1", out_valid);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_u     = 32'h55AA55AA;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_in_ready: got %b expected 0", in_ready);
    end
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid);
    end
    vectors++;
    if (beat_cnt !== exp_cnt) begin
      miscompares++;
      $display("[TB] FAIL flush_beat_cnt: got %0d expected %0d", beat_cnt, exp_cnt);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_ready_after: got %b expected 1", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      if (out_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("[TB] FAIL flush_ghost: got %0d outputs expected 0", seen);
    end
    in_valid = 1'b1;
    in_u     = 32'h81800100;
    tick();
    exp_cnt++;
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_t !== golden(32'h81800100)) begin
      miscompares++;
      $display("[TB] FAIL flush_recover: got %b/%h expected 1/%h",
               out_valid, out_t, golden(32'h81800100));
    end
    tick();
  endtask

  task automatic test_wrap_reset();
    int acc = 0;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      in_valid = 1'b1;
      in_u     = {4{c[7:0]}};
      #1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    vectors++;
    if (acc != 17) begin
      miscompares++;
      $display("[TB] FAIL wrap_accepted: got %0d expected 17", acc);
    end
    vectors++;
    if (beat_cnt !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL wrap_beat_cnt: got %0d expected 1", beat_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_u     = 32'hC3C3C3C3 ^ c;
      tick();
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_prefill: got %b expected 1", out_valid);
    end
    reset_n = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_t !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_out: got %b/%h expected 0/0", out_valid, out_t);
    end
    vectors++;
    if (beat_cnt !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_beat_cnt: got %0d expected 0", beat_cnt);
    end
    reset_n  = 1'b1;
    in_valid = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_in_ready: got %b expected 1", in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_ghost: got %b expected 0", out_valid);
    end
  endtask

`ifdef TOP_LINEAR_PARITY_EN
  task automatic test_parity();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_u      = {4{8'h01}};
    tick();
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || par_err !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL parity_clean: got %b/%b expected 1/0000", out_valid, par_err);
    end
    force dut.out_t = golden({4{8'h01}}) ^ (108'd1 << 27);
    #1;
    vectors++;
    if (par_err !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL parity_flip: got %b expected 0010", par_err);
    end
    release dut.out_t;
    out_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b0 || par_err !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL parity_idle: got %b/%b expected 0/0000", out_valid, par_err);
    end
  endtask
`endif

  initial begin
    $display("[TB] starting top_linear_pipe bench");
    test_reset();
    test_spec_vectors();
    test_sweep();
    test_back_to_back_stall();
    test_flush();
    test_wrap_reset();
`ifdef TOP_LINEAR_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
